// File: rtl/overture_pkg.sv
// Shared types, constants and the branch-condition evaluator for the Overture
// fetch/decode/execute sequencer.
package overture_pkg;

    typedef enum logic [1:0] {
        OP_IMM  = 2'b00,
        OP_CALC = 2'b01,
        OP_COPY = 2'b10,
        OP_COND = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_OR   = 3'd0,
        ALU_NAND = 3'd1,
        ALU_NOR  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_ADD  = 3'd4,
        ALU_SUB  = 3'd5,
        ALU_ZER6 = 3'd6,
        ALU_ZER7 = 3'd7
    } alu_op_e;

    typedef enum logic [2:0] {
        COND_NEVER   = 3'd0,
        COND_EQ      = 3'd1,
        COND_NEG     = 3'd2,
        COND_LE      = 3'd3,
        COND_ALWAYS  = 3'd4,
        COND_NE      = 3'd5,
        COND_GE      = 3'd6,
        COND_GREATER = 3'd7
    } cond_e;

    typedef enum logic [1:0] {
        ST_FETCH    = 2'd0,
        ST_EXEC     = 2'd1,
        ST_IN_WAIT  = 2'd2,
        ST_OUT_WAIT = 2'd3
    } state_e;

    localparam int         NUM_REGS  = 6;
    localparam logic [2:0] IO_CODE   = 3'd6;

    // r3 is treated as a signed byte: bit 7 is "negative", all-zero is "zero".
    function automatic logic cond_eval(input logic [7:0] r3, input cond_e cond);
        logic is_zero;
        logic is_neg;
        logic res;
        is_zero = (r3 == 8'h00);
        is_neg  = r3[7];
        res     = 1'b0;
        case (cond)
            COND_NEVER:   res = 1'b0;
            COND_EQ:      res = is_zero;
            COND_NEG:     res = is_neg;
            COND_LE:      res = is_neg | is_zero;
            COND_ALWAYS:  res = 1'b1;
            COND_NE:      res = ~is_zero;
            COND_GE:      res = ~is_neg;
            COND_GREATER: res = ~is_neg & ~is_zero;
            default:      res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/overture_if.sv
// System-side bus of the Overture sequencer: instruction fetch, byte input
// port and byte output port, each a valid/ready style handshake.
interface overture_if #(
    parameter int PC_W = 8
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_valid;
    logic [7:0]      imem_data;

    logic            in_ready;
    logic            in_valid;
    logic [7:0]      in_data;

    logic            out_valid;
    logic [7:0]      out_data;
    logic            out_ready;

    // Sequencer side.
    modport master (
        output imem_req, imem_addr, in_ready, out_valid, out_data,
        input  imem_valid, imem_data, in_valid, in_data, out_ready
    );

    // ROM / I/O port side.
    modport slave (
        input  imem_req, imem_addr, in_ready, out_valid, out_data,
        output imem_valid, imem_data, in_valid, in_data, out_ready
    );
endinterface

// File: rtl/overture_alu.sv
// Combinational ALU for the calculate class: r3 = f(r1, r2).
module overture_alu
    import overture_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  alu_op_e    op_i,
    output logic [7:0] result_o
);

    // Operation select; the two spare codes yield zero.
    always_comb begin
        result_o = 8'h00;
        case (op_i)
            ALU_OR:   result_o = a_i | b_i;
            ALU_NAND: result_o = ~(a_i & b_i);
            ALU_NOR:  result_o = ~(a_i | b_i);
            ALU_AND:  result_o = a_i & b_i;
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            default:  result_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/overture_sequencer.sv
// Overture CPU sequencer: fetches one instruction byte per instruction, owns
// r0-r5 and the PC, and moves bytes between registers and the I/O ports.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   ST_FETCH    | imem_req high, waiting for imem_valid to latch ir
//   ST_EXEC     | decode ir, update registers / PC, or start an I/O copy
//   ST_IN_WAIT  | in_ready high, waiting for an input byte
//   ST_OUT_WAIT | out_valid high, holding out_data until out_ready
module overture_sequencer
    import overture_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    overture_if.master      bus,
    output logic [PC_W-1:0] pc_o,
    output logic            retire
);

    state_e                     state_q, state_d;
    logic [PC_W-1:0]            pc_q, pc_d;
    logic [NUM_REGS-1:0][7:0]   regs_q, regs_d;
    logic [7:0]                 ir_q, ir_d;
    logic                       out_valid_q, out_valid_d;
    logic [7:0]                 out_data_q, out_data_d;
    logic                       retire_q, retire_d;

    opcode_e                    opc;
    logic [2:0]                 src_code;
    logic [2:0]                 dst_code;
    logic [PC_W-1:0]            pc_inc;
    logic [7:0]                 alu_res;
    logic [7:0]                 src_val;

    logic                       wr_en;
    logic [2:0]                 wr_code;
    logic [7:0]                 wr_val;
    logic                       advance;
    logic                       jump;

    assign opc      = opcode_e'(ir_q[7:6]);
    assign src_code = ir_q[5:3];
    assign dst_code = ir_q[2:0];
    assign pc_inc   = pc_q + PC_W'(1);

    overture_alu u_alu (
        .a_i      (regs_q[1]),
        .b_i      (regs_q[2]),
        .op_i     (alu_op_e'(ir_q[2:0])),
        .result_o (alu_res)
    );

    // Copy source read: codes above r5 read as zero (I/O is handled by the FSM).
    always_comb begin
        src_val = 8'h00;
        if (src_code < 3'(NUM_REGS)) begin
            src_val = regs_q[src_code];
        end
    end

    // Next-state logic; register writes and instruction completion are
    // collected in wr_* / advance and applied once after the state case.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        regs_d      = regs_q;
        ir_d        = ir_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        retire_d    = 1'b0;
        wr_en       = 1'b0;
        wr_code     = 3'd0;
        wr_val      = 8'h00;
        advance     = 1'b0;
        jump        = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (bus.imem_valid) begin
                    ir_d    = bus.imem_data;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (opc)
                    OP_IMM: begin
                        wr_en   = 1'b1;
                        wr_code = 3'd0;
                        wr_val  = {2'b00, ir_q[5:0]};
                        advance = 1'b1;
                    end
                    OP_CALC: begin
                        wr_en   = 1'b1;
                        wr_code = 3'd3;
                        wr_val  = alu_res;
                        advance = 1'b1;
                    end
                    OP_COPY: begin
                        if (src_code == IO_CODE) begin
                            state_d = ST_IN_WAIT;
                        end else if (dst_code == IO_CODE) begin
                            out_data_d  = src_val;
                            out_valid_d = 1'b1;
                            state_d     = ST_OUT_WAIT;
                        end else begin
                            wr_en   = 1'b1;
                            wr_code = dst_code;
                            wr_val  = src_val;
                            advance = 1'b1;
                        end
                    end
                    OP_COND: begin
                        jump    = cond_eval(regs_q[3], cond_e'(ir_q[2:0]));
                        advance = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_IN_WAIT: begin
                if (bus.in_valid) begin
                    if (dst_code == IO_CODE) begin
                        out_data_d  = bus.in_data;
                        out_valid_d = 1'b1;
                        state_d     = ST_OUT_WAIT;
                    end else begin
                        wr_en   = 1'b1;
                        wr_code = dst_code;
                        wr_val  = bus.in_data;
                        advance = 1'b1;
                    end
                end
            end
            ST_OUT_WAIT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    advance     = 1'b1;
                end
            end
            default: state_d = ST_FETCH;
        endcase

        // Destination code 7 falls outside the register file and is dropped.
        if (wr_en && (wr_code < 3'(NUM_REGS))) begin
            regs_d[wr_code] = wr_val;
        end

        // Branch targets come from r0, truncated or zero-extended to PC_W.
        if (advance) begin
            pc_d     = jump ? PC_W'(regs_q[0]) : pc_inc;
            retire_d = 1'b1;
            state_d  = ST_FETCH;
        end
    end

    // State and datapath registers; reset also drops a pending out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            regs_q      <= '0;
            ir_q        <= 8'h00;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            retire_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            regs_q      <= regs_d;
            ir_q        <= ir_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            retire_q    <= retire_d;
        end
    end

    assign bus.imem_req  = (state_q == ST_FETCH);
    assign bus.imem_addr = pc_q;
    assign bus.in_ready  = (state_q == ST_IN_WAIT);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign pc_o          = pc_q;
    assign retire        = retire_q;

endmodule

// File: doc/overture_sequencer.md
Name: overture_sequencer

Overview:
- Multi-cycle fetch/decode/execute controller for the 8-bit Overture CPU.
- Fetches instructions over a variable-latency instruction-memory handshake and owns the register file r0–r5 and the PC.
- Executes the four Overture instruction classes: immediate, calculate, copy, condition.
- Resolves branches by evaluating the 3-bit condition field against r3; on a taken branch it loads the PC from r0.
- Sits between the program ROM and the external byte-wide I/O ports.

Parameters:
- PC_W, 8, PC / instruction-address width. PC wraps modulo 2^PC_W.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request; high exactly while state==FETCH.
- imem_addr  out  PC_W  fetch address, equal to pc.
- imem_valid  in  1  imem_data valid; accepted only while imem_req=1.
- imem_data  in  8  instruction byte.
- in_ready  out  1  high while state==IN_WAIT.
- in_valid  in  1  input byte available.
- in_data  in  8  input byte.
- out_valid  out  1  registered; output byte presented.
- out_data  out  8  registered output byte.
- out_ready  in  1  consumer accepts out_data.
- pc_o  out  PC_W  current PC, for debug.
- retire  out  1  one-cycle pulse when an instruction completes.

Behaviour:
- Reset (async, while rst_n=0):
  - pc=RESET_PC; r0–r5=0; ir=0.
  - state=FETCH; out_valid=0; out_data=0; retire=0.
  - imem_req therefore rises as soon as rst_n deasserts.
- States: FETCH, EXEC, IN_WAIT, OUT_WAIT.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_valid: ir<=imem_data, go to EXEC next cycle.
  - Without imem_valid, hold indefinitely.
  - Minimum instruction latency is 2 cycles (imem_valid in the first FETCH cycle).
- EXEC, decode on ir[7:6]:
  - 00 immediate: r0<={2'b00, ir[5:0]}.
  - 01 calculate: r3<=f(r1,r2), selected by ir[2:0]:
    - 0 OR, 1 NAND, 2 NOR, 3 AND.
    - 4 ADD, mod 256, carry discarded.
    - 5 SUB, r1-r2 mod 256.
    - 6 and 7: result 0x00.
  - 10 copy, src=ir[5:3], dst=ir[2:0]:
    - Register codes 0–5 = r0–r5.
    - Code 6 = I/O.
    - Code 7 as source reads 0x00; code 7 as destination discards the write.
    - src=6: go to IN_WAIT.
    - Else if dst=6: out_data<=src value, out_valid<=1, go to OUT_WAIT.
    - Else: plain register write.
  - 11 condition: evaluate cond=ir[2:0] against current r3:
    - 0 never; 1 r3==0; 2 r3[7]; 3 r3[7] or r3==0.
    - 4 always; 5 r3!=0; 6 !r3[7]; 7 !r3[7] and r3!=0.
    - Taken: pc<=r0[PC_W-1:0]. Not taken: pc<=pc+1.
  - All non-I/O instructions: pc<=pc+1 (unless branch taken), retire=1, go to FETCH.
- IN_WAIT:
  - in_ready=1.
  - On in_valid: capture in_data.
    - If dst=6: out_data<=in_data, out_valid<=1, go to OUT_WAIT (no retire yet).
    - Else: write dst (code 7 discards), pc+1, retire=1, go to FETCH.
- OUT_WAIT:
  - out_valid stays high and out_data stays stable until out_ready.
  - On the out_ready cycle: out_valid<=0, pc+1, retire=1, go to FETCH.
- PC wrap: pc=2^PC_W-1 plus 1 gives 0. A branch target wider than PC_W is truncated.
- Write ordering: a calculate that writes r3 is visible to a condition in the next instruction; there is no forwarding hazard because execution is serial.
- Reset mid-operation, any state: immediate return to reset values. Any pending out_valid drops asynchronously.
- imem_valid, in_valid and out_ready are ignored outside their owning state.

Decomposition:
- Package overture_pkg:
  - opcode enum (IMM, CALC, COPY, COND).
  - alu_op enum.
  - cond_e enum (NEVER … GREATER).
  - state enum.
  - IO_CODE=3'd6.
  - cond_eval(r3, cond) function.
- Sub-module overture_alu: combinational, (a, b, op) -> result.
- Register file and FSM remain in overture_sequencer.

Test Plan:
- Immediate plus ALU:
  - Program 0x05 (r0=5), 0x81 (copy r0->r1), 0x02 (r0=2), 0x82 (r0->r2), 0x44 (ADD).
  - Required: r3=0x07 and 5 retire pulses.
  - Repeat with 0x45 (SUB). Required: r3=0x03.
- Branch taken/not taken:
  - r3=0x00, r0=0x10, instruction 0xC1 (eq). Required: pc_o=0x10.
  - r3=0x80, instruction 0xC7 (greater). Required: pc_o advances by 1.
  - Required: cond 4 always taken, cond 0 never taken.
- I/O copy 0xB6 (in->out):
  - in_valid held low 3 cycles then in_data=0xA5. Required: in_ready high throughout the wait.
  - out_ready held low 2 cycles. Required: out_valid=1 and out_data=0xA5 stable until accepted.
  - Required: a single retire pulse, after out_ready.
- Fetch stall: imem_valid delayed 4 cycles. Required: imem_req and imem_addr stable during the stall, and no state change.
- PC wrap: pc=0xFF, non-branch instruction. Required: next imem_addr=0x00.
- Async reset asserted in OUT_WAIT. Required: out_valid=0 immediately, pc_o=RESET_PC, r3=0, and imem_req=1 after release.
